// File: rtl/hilo_ctrl.sv
// HI/LO write-path sequencer: accepts one MULT/DIV/MTHI/MTLO op, runs the unit, issues one write cycle.
// Optional HILO_DIV0_SKIP_EN: a division accepted with div_zero=1 skips the divider and the write.
module hilo_ctrl #(
  parameter int WAIT_MAX = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  input  logic [2:0] op_code,
  output logic       op_ready,
  output logic       busy,
  output logic       mult_start,
  output logic       mult_signed,
  input  logic       mult_done,
  output logic       div_start,
  output logic       div_signed,
  input  logic       div_done,
  input  logic       div_zero,
  output logic       MUX_LO_WDATA_DIV,
  output logic       MUX_LO_WDATA_MULT,
  output logic       MUX_LO_WDATA_RS,
  output logic       MUX_HI_WDATA_DIV,
  output logic       MUX_HI_WDATA_MULT,
  output logic       MUX_HI_WDATA_RS,
  output logic       LO_WENA,
  output logic       HI_WENA,
  output logic       timeout,
  output logic       illegal_op
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, MULT_WAIT, DIV_WAIT, WRITE} state_t;

  typedef struct packed {
    logic lo_div;
    logic lo_mult;
    logic lo_rs;
    logic hi_div;
    logic hi_mult;
    logic hi_rs;
    logic lo_wena;
    logic hi_wena;
  } wr_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            skip_q, skip_d;
  logic            mult_start_d, div_start_d, timeout_d, illegal_d;
  wr_t             wr_q, wr_d;

`ifndef HILO_DIV0_SKIP_EN
  logic unused_div_zero;
  assign unused_div_zero = div_zero;
`endif

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    skip_d       = skip_q;
    mult_start_d = 1'b0;
    div_start_d  = 1'b0;
    timeout_d    = 1'b0;
    illegal_d    = 1'b0;
    wr_d         = '0;

    case (state_q)
      IDLE: begin
        skip_d = 1'b0;
        cnt_d  = '0;
        if (op_valid) begin
          if (op_code > OP_MTLO) begin
            illegal_d = 1'b1;
          end else begin
            op_d = op_code;
            case (op_code[2:1])
              2'b00: begin
                state_d      = MULT_WAIT;
                mult_start_d = 1'b1;
              end
              2'b01: begin
`ifdef HILO_DIV0_SKIP_EN
                if (div_zero) begin
                  state_d = WRITE;
                  skip_d  = 1'b1;
                end else begin
                  state_d     = DIV_WAIT;
                  div_start_d = 1'b1;
                end
`else
                state_d     = DIV_WAIT;
                div_start_d = 1'b1;
`endif
              end
              default: state_d = WRITE;
            endcase
          end
        end
      end
      MULT_WAIT, DIV_WAIT: begin
        // Done is checked before the limit so a last-cycle completion still writes.
        if ((state_q == MULT_WAIT) ? mult_done : div_done) begin
          state_d = WRITE;
        end else if (cnt_q == CW'(WAIT_MAX)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the upcoming state.
    if (state_d == WRITE && !skip_d) begin
      case (op_d)
        OP_MTLO: begin
          wr_d.lo_rs   = 1'b1;
          wr_d.lo_wena = 1'b1;
        end
        OP_MTHI: begin
          wr_d.hi_rs   = 1'b1;
          wr_d.hi_wena = 1'b1;
        end
        default: begin
          wr_d.lo_mult = ~op_d[1];
          wr_d.hi_mult = ~op_d[1];
          wr_d.lo_div  = op_d[1];
          wr_d.hi_div  = op_d[1];
          wr_d.lo_wena = 1'b1;
          wr_d.hi_wena = 1'b1;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      skip_q      <= 1'b0;
      op_ready    <= 1'b1;
      busy        <= 1'b0;
      mult_start  <= 1'b0;
      div_start   <= 1'b0;
      mult_signed <= 1'b0;
      div_signed  <= 1'b0;
      timeout     <= 1'b0;
      illegal_op  <= 1'b0;
      wr_q        <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      skip_q      <= skip_d;
      op_ready    <= (state_d == IDLE);
      busy        <= (state_d != IDLE);
      mult_start  <= mult_start_d;
      div_start   <= div_start_d;
      mult_signed <= (state_d != IDLE) && (op_d == OP_MULT);
      div_signed  <= (state_d != IDLE) && (op_d == OP_DIV);
      timeout     <= timeout_d;
      illegal_op  <= illegal_d;
      wr_q        <= wr_d;
    end
  end

  assign MUX_LO_WDATA_DIV  = wr_q.lo_div;
  assign MUX_LO_WDATA_MULT = wr_q.lo_mult;
  assign MUX_LO_WDATA_RS   = wr_q.lo_rs;
  assign MUX_HI_WDATA_DIV  = wr_q.hi_div;
  assign MUX_HI_WDATA_MULT = wr_q.hi_mult;
  assign MUX_HI_WDATA_RS   = wr_q.hi_rs;
  assign LO_WENA           = wr_q.lo_wena;
  assign HI_WENA           = wr_q.hi_wena;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: directed sequences plus random traffic against a
// transaction-level model that derives every output from accept/done cycle numbers.
module tb_hilo_ctrl;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic [2:0] op_code = '0;
  logic       mult_done = 1'b0;
  logic       div_done = 1'b0;
  logic       div_zero = 1'b0;
  logic       op_ready, busy, mult_start, mult_signed, div_start, div_signed;
  logic       mux_lo_div, mux_lo_mult, mux_lo_rs, mux_hi_div, mux_hi_mult, mux_hi_rs;
  logic       lo_wena, hi_wena, timeout, illegal_op;

  hilo_ctrl #(.WAIT_MAX(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .op_valid         (op_valid),
    .op_code          (op_code),
    .op_ready         (op_ready),
    .busy             (busy),
    .mult_start       (mult_start),
    .mult_signed      (mult_signed),
    .mult_done        (mult_done),
    .div_start        (div_start),
    .div_signed       (div_signed),
    .div_done         (div_done),
    .div_zero         (div_zero),
    .MUX_LO_WDATA_DIV (mux_lo_div),
    .MUX_LO_WDATA_MULT(mux_lo_mult),
    .MUX_LO_WDATA_RS  (mux_lo_rs),
    .MUX_HI_WDATA_DIV (mux_hi_div),
    .MUX_HI_WDATA_MULT(mux_hi_mult),
    .MUX_HI_WDATA_RS  (mux_hi_rs),
    .LO_WENA          (lo_wena),
    .HI_WENA          (hi_wena),
    .timeout          (timeout),
    .illegal_op       (illegal_op)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Pending-operation record: accept cycle, first qualifying done cycle (-1 if none yet).
  bit         m_act  = 1'b0;
  bit         m_skip = 1'b0;
  bit         m_ill  = 1'b0;
  logic [2:0] m_op   = '0;
  int         m_tacc = 0;
  int         m_done = -1;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  // Select/enable pattern {lo_div,lo_mult,lo_rs,hi_div,hi_mult,hi_rs,lo_wena,hi_wena} per op.
  function automatic logic [7:0] wr_of(input logic [2:0] op);
    case (op)
      3'b000, 3'b001: return 8'b010_010_11;
      3'b010, 3'b011: return 8'b100_100_11;
      3'b101:         return 8'b001_000_10;
      default:        return 8'b000_001_01;
    endcase
  endfunction

  task automatic step(input logic v, input logic [2:0] code, input logic md, input logic dd,
                      input logic dz, input bit rst);
    int   fin;
    int   e;
    bit   tmo_cand;
    bit   tmo;
    bit   ill_next;
    logic [7:0] exp_wr;
    @(negedge clk);
    cyc++;
    if (rst) begin
      rst_n = 1'b0;
      #1;
      m_act = 1'b0;
      m_ill = 1'b0;
    end else begin
      rst_n = 1'b1;
    end

    tmo = 1'b0;
    tmo_cand = 1'b0;
    if (m_act) begin
      if (m_op >= 3'd4 || m_skip) fin = m_tacc + 2;
      else if (m_done >= 0)       fin = m_done + 2;
      else begin
        fin = m_tacc + W + 2;
        tmo_cand = 1'b1;
      end
      if (cyc >= fin) begin
        m_act = 1'b0;
        tmo = tmo_cand;
      end
    end
    e = cyc - m_tacc;

    exp_wr = '0;
    if (m_act && !m_skip) begin
      if (m_op >= 3'd4) begin
        if (e == 1) exp_wr = wr_of(m_op);
      end else if (m_done >= 0 && cyc == m_done + 1) begin
        exp_wr = wr_of(m_op);
      end
    end

    check("op_ready", {7'b0, op_ready}, {7'b0, !m_act});
    check("busy", {7'b0, busy}, {7'b0, m_act});
    check("pulses", {4'b0, mult_start, div_start, timeout, illegal_op},
          {4'b0, m_act && e == 1 && m_op[2:1] == 2'b00,
                 m_act && e == 1 && m_op[2:1] == 2'b01 && !m_skip, tmo, m_ill});
    check("signed", {6'b0, mult_signed, div_signed},
          {6'b0, m_act && m_op == 3'b000, m_act && m_op == 3'b010});
    check("write", {mux_lo_div, mux_lo_mult, mux_lo_rs, mux_hi_div, mux_hi_mult, mux_hi_rs,
                    lo_wena, hi_wena}, exp_wr);

    op_valid  = v;
    op_code   = code;
    mult_done = md;
    div_done  = dd;
    div_zero  = dz;

    ill_next = 1'b0;
    if (!rst) begin
      if (m_act && m_op < 3'd4 && !m_skip && m_done < 0 && (m_op[1] ? dd : md)) m_done = cyc;
      if (!m_act && v) begin
        if (code > 3'd5) begin
          ill_next = 1'b1;
        end else begin
          m_act  = 1'b1;
          m_op   = code;
          m_tacc = cyc;
          m_done = -1;
`ifdef HILO_DIV0_SKIP_EN
          m_skip = (code[2:1] == 2'b01) && dz;
`else
          m_skip = 1'b0;
`endif
        end
      end
    end
    m_ill = ill_next;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset values, then MTLO write timing.
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    step(1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // MULT with done three cycles after the start pulse.
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    // DIVU, same shape; stray mult_done must be ignored.
    step(1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    // DIV timeout, then DIV with done in the final waiting cycle.
    step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(W + 3);
    step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(W);
    step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    // Reset in DIV_WAIT followed by a late div_done.
    step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    // Op while busy is dropped; illegal code in IDLE pulses illegal_op.
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Division with zero divisor (skip or normal run depending on build).
    step(1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 3) == 0), $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencer for the HI/LO register write path of the multi-cycle CPU. Accepts one HI/LO operation at a time from the control FSM (MULT, MULTU, DIV, DIVU, MTHI, MTLO), starts the multiplier or divider, waits for completion and drives the HI/LO write-data select lines and write enables for exactly one cycle. Provides a busy/ready indication so the control FSM stalls MFHI/MFLO and further HI/LO ops while an operation is in flight.

## Interface
Parameters:
- WAIT_MAX, 64: max cycles spent waiting for mult_done/div_done before abort; counter width is $clog2(WAIT_MAX+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  control FSM presents an op.
- op_code  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 illegal.
- op_ready  out  1  high only in IDLE; op accepted when op_valid && op_ready.
- busy  out  1  ~op_ready.
- mult_start  out  1  one-cycle start pulse to multiplier.
- mult_signed  out  1  held from accept until return to IDLE; 1 for MULT.
- mult_done  in  1  multiplier result valid.
- div_start  out  1  one-cycle start pulse to divider.
- div_signed  out  1  held like mult_signed; 1 for DIV.
- div_done  in  1  divider result valid.
- div_zero  in  1  divisor is zero, valid in accept cycle.
- MUX_LO_WDATA_DIV, MUX_LO_WDATA_MULT, MUX_LO_WDATA_RS  out  1 each  LO source selects.
- MUX_HI_WDATA_DIV, MUX_HI_WDATA_MULT, MUX_HI_WDATA_RS  out  1 each  HI source selects.
- LO_WENA, HI_WENA  out  1 each  write enables.
- timeout  out  1  one-cycle pulse on wait abort.
- illegal_op  out  1  one-cycle pulse on illegal op_code.

## Operation
- States: IDLE, MULT_WAIT, DIV_WAIT, WRITE.
- IDLE: accept MULT/MULTU -> MULT_WAIT; DIV/DIVU -> DIV_WAIT; MTHI/MTLO -> WRITE. Latch op_code internally.
- Illegal code with op_valid: stay IDLE, illegal_op pulses next cycle, op_ready stays 1.
- MULT_WAIT/DIV_WAIT: start pulse in first cycle of state; wait counter cleared on entry, increments each cycle; done sampled every cycle of the state including the start cycle.
- done -> WRITE. Counter == WAIT_MAX without done -> IDLE, timeout pulse, no write. Done and counter==WAIT_MAX same cycle: done wins.
- WRITE (one cycle): MULT/DIV ops assert both selects of their unit plus LO_WENA and HI_WENA; MTLO asserts MUX_LO_WDATA_RS + LO_WENA only; MTHI asserts MUX_HI_WDATA_RS + HI_WENA only. Then IDLE.
- Per register, selects one-hot or all zero; all selects/enables zero outside WRITE.
- mult_done/div_done outside their WAIT state ignored; op_valid while busy ignored (not queued).

## Timing
- All outputs registered. Reset value: op_ready=1, busy=0, every other output 0, state IDLE, counter 0.
- MTHI/MTLO: accept cycle T, write cycle T+1, op_ready high T+2.
- MULT/DIV: accept T, start pulse T+1; done in cycle D≥T+1 -> write D+1, op_ready D+2.
- Timeout: accept T, no done -> timeout pulse and op_ready high at T+1+WAIT_MAX+1.
- rst_n low mid-operation: immediate return to reset values, no write issued, in-flight op discarded.

## Configuration
- HILO_DIV0_SKIP_EN defined: DIV/DIVU accepted with div_zero=1 goes IDLE -> WRITE-less skip: no div_start, no write, op_ready high again 2 cycles after accept (one-cycle SKIP pass through WRITE with enables forced 0).
- Not defined: div_zero ignored; division with zero divisor runs normally and writes whatever the divider returns.

## Test plan
- Reset: rst_n=0 -> op_ready=1, all selects/enables/pulses 0.
- MTLO accepted at T -> T+1 MUX_LO_WDATA_RS=1, LO_WENA=1, HI_WENA=0; op_ready=1 at T+2.
- MULT, mult_done 3 cycles after start -> mult_start one cycle, mult_signed=1, write cycle asserts MUX_LO/HI_WDATA_MULT and both WENAs; DIVU same with DIV selects, div_signed=0.
- WAIT_MAX=4, DIV with no div_done -> timeout pulse, no WENA, op_ready back; repeat with div_done in final cycle -> write occurs, no timeout.
- Reset asserted in DIV_WAIT, then div_done -> no write; op_valid while busy and op_code=111 in IDLE -> op ignored, illegal_op pulse.
- With HILO_DIV0_SKIP_EN: DIV with div_zero=1 -> no div_start, no WENA, op_ready high at T+2; without macro -> normal division sequence.
